// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word fetches
// to instruction memory and loads the IF/ID pipeline register for id_stage.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        take_branch,
    input  logic [31:0] target_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic        if_id_valid_inst
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;

    logic        load;
    logic [31:0] load_word;
    logic        req_valid;
    logic [31:0] tgt;

    // Fetch FSM: next state, PC, skid buffer and the "load IF/ID" strobe.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        load      = 1'b0;
        load_word = '0;
        req_valid = 1'b0;
        tgt       = target_pc & 32'hFFFF_FFFC;
        case (state_q)
            S_REQ: begin
                req_valid = 1'b1;
                if (take_branch) begin
                    pc_d = tgt;
                    if (imem_req_ready) state_d = S_DISCARD;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (take_branch) begin
                        pc_d = tgt;
                    end else if (stall_if) begin
                        buf_d   = imem_rsp_data;
                        state_d = S_HOLD;
                    end else begin
                        load      = 1'b1;
                        load_word = imem_rsp_data;
                        pc_d      = pc_q + 32'd4;
                    end
                end else if (take_branch) begin
                    pc_d    = tgt;
                    state_d = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (take_branch) begin
                    pc_d    = tgt;
                    state_d = S_REQ;
                end else if (!stall_if) begin
                    load      = 1'b1;
                    load_word = buf_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = S_REQ;
                end
            end
            S_DISCARD: begin
                if (take_branch) pc_d = tgt;
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // IF/ID register: flush beats stall, stall beats load, otherwise a bubble.
    always_comb begin
        ir_d    = ir_q;
        ifpc_d  = ifpc_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (take_branch) begin
            ir_d    = NOP_INST;
            valid_d = 1'b0;
        end else if (!stall_if) begin
            if (load) begin
                ir_d    = load_word;
                ifpc_d  = pc_q;
                npc_d   = pc_q + 32'd4;
                valid_d = 1'b1;
            end else begin
                ir_d    = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            ir_q    <= NOP_INST;
            ifpc_q  <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            ir_q    <= ir_d;
            ifpc_q  <= ifpc_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req_valid   = req_valid & ~rst;
    assign imem_req_addr    = pc_q;
    assign if_id_IR         = ir_q;
    assign if_id_PC         = ifpc_q;
    assign if_id_NPC        = npc_q;
    assign if_id_valid_inst = valid_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage for the 5-stage RV32 pipeline. Holds the PC and issues word fetches to instruction memory over a valid/ready request and valid-only response interface, with one request outstanding at a time. It loads the IF/ID pipeline register (`if_id_IR`, `if_id_PC`, `if_id_NPC`, `if_id_valid_inst`) that feeds `id_stage`. It also handles hazard stalls and branch/jump redirects from downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `NOP_INST`, default 32'h0000_0013: `addi x0,x0,0`, driven on `if_id_IR` when no valid instruction is present.

Ports:
- `clk`, in, 1: system clock. The block uses one clock.
- `rst`, in, 1: synchronous, active-high reset.
- `stall_if`, in, 1: hold the IF/ID register and PC (load-use hazard).
- `take_branch`, in, 1: redirect fetch to `target_pc` and flush IF/ID.
- `target_pc`, in, 32: redirect address, word aligned.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_addr`, out, 32: fetch address, equal to the internal PC.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_rsp_valid`, in, 1: response word valid. Asserted exactly once per accepted request, no earlier than the cycle after acceptance.
- `imem_rsp_data`, in, 32: fetched instruction.
- `if_id_IR`, out, 32: registered instruction.
- `if_id_PC`, out, 32: registered PC of `if_id_IR`.
- `if_id_NPC`, out, 32: registered `if_id_PC + 4`.
- `if_id_valid_inst`, out, 1: IF/ID contents are a real instruction.

## Operation
Internal state:
- `pc_r` (32 bits) and `buf_r` (32-bit skid buffer).
- FSM with states REQ, WAIT, HOLD, DISCARD.

Priority rule: `rst` > `take_branch` > `stall_if`.

REQ:
- Drives `imem_req_valid`=1 and `imem_req_addr`=`pc_r`.
- If `take_branch` and `imem_req_ready`: the accepted request is stale. `pc_r`<=`target_pc`, go to DISCARD.
- If `take_branch` and not `imem_req_ready`: `pc_r`<=`target_pc`, stay in REQ. This is the only case where the address may change while valid is high.
- Otherwise, on `imem_req_ready`: go to WAIT.

WAIT:
- Drives `imem_req_valid`=0.
- On `imem_rsp_valid`:
  - With `take_branch`: drop the word, `pc_r`<=`target_pc`, go to REQ.
  - With `stall_if`: `buf_r`<=`imem_rsp_data`, go to HOLD.
  - Otherwise: load IF/ID from `imem_rsp_data` and `pc_r`, `pc_r`<=`pc_r+4`, go to REQ.
- With `take_branch` and no response: `pc_r`<=`target_pc`, go to DISCARD.

HOLD:
- Drives `imem_req_valid`=0.
- With `take_branch`: drop `buf_r`, `pc_r`<=`target_pc`, go to REQ.
- Else with `!stall_if`: load IF/ID from `buf_r` and `pc_r`, `pc_r`<=`pc_r+4`, go to REQ.

DISCARD:
- Drives `imem_req_valid`=0. Waits for the stale response and drops it, then goes to REQ.
- `take_branch` here updates `pc_r`<=`target_pc` and stays in DISCARD unless the response arrives the same cycle, in which case it goes to REQ.

IF/ID register update, each cycle:
- `take_branch`: `if_id_valid_inst`<=0 and `if_id_IR`<=`NOP_INST`. PC and NPC hold.
- Else `stall_if`: all IF/ID fields hold.
- Else, if a load occurs: IR, PC and NPC<=PC+4 are written and valid<=1.
- Else: a bubble is written, with valid<=0 and IR<=`NOP_INST`. PC and NPC hold.

Arithmetic: PC increment is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Bits [1:0] of `target_pc` are ignored and forced to 0.

## Timing
Reset values, applied on any clock edge with `rst` high, including mid-transaction:
- `pc_r`=`RESET_PC` and state=REQ.
- `if_id_IR`=`NOP_INST`, `if_id_PC`=0, `if_id_NPC`=0, `if_id_valid_inst`=0.
- `imem_req_valid` is forced to 0 while `rst` is high.

Reset does not track an outstanding response. The memory is reset alongside this block, and any response arriving in REQ is ignored.

Latency and throughput:
- Request accepted at cycle N, response at N+k (k≥1): the instruction is visible on IF/ID at N+k+1, unless stalled.
- Steady state with k=1 is one instruction every 2 cycles.
- Redirect at cycle M with the request not yet accepted: the new address is on `imem_req_addr` at M+1.
- `imem_req_valid` stays high in REQ until `imem_req_ready` is seen. Only a redirect may change the address while valid is high.

## Test plan
- Reset release with `RESET_PC`=0x100 and 1-cycle memory holding sequential words: addresses 0x100, 0x104, 0x108 are issued; IF/ID shows PC 0x100/NPC 0x104, valid=1, one instruction per 2 cycles, bubbles in between.
- `stall_if` held 3 cycles across a response: the word is captured in HOLD; IF/ID is frozen for 3 cycles; the word appears the cycle after the stall drops with the correct PC; no fetch is issued during the stall.
- `take_branch` with `target_pc`=0x200 while in WAIT: IF/ID valid=0 next cycle; the stale response is dropped; the next request address is 0x200; the first valid IF/ID has PC 0x200.
- Redirect in REQ with `imem_req_ready`=0, then ready: the address switches to the target without an extra request; redirect coincident with acceptance goes to DISCARD and the stale word is never loaded.
- `take_branch` and `stall_if` asserted together in HOLD: flush wins; `buf_r` is dropped; fetch resumes at the target.
- PC 0xFFFF_FFFC fetched: NPC=0 and the next address is 0x0. `rst` asserted mid-WAIT: all outputs take their reset values the next cycle.
